reg_read_stage: RTL and testbench
=================================

Name: reg_read_stage

Overview:
- Decode-side reader of the 32x32 register file, with two read ports and one write port. The register file writes on negedge; pipeline registers update on posedge.
- Accepts decoded instructions over a valid/ready handshake and drives the register file read addresses.
- Tracks pending destination writes in a busy-bit scoreboard, stalls on RAW/WAW hazards and bypasses same-cycle writeback data.
- Presents registered operands to the execute stage over a second valid/ready handshake.

Parameters:
XLEN, 32, data width of register file and operands
PAYLOAD_W, 32, width of opaque instruction payload (pc/opcode/imm) carried alongside

Ports:
clk  in  1  clock; all state updates on posedge
rst_n  in  1  asynchronous active-low reset
flush  in  1  kill held output instruction (branch redirect)
in_valid  in  1  decoded instruction available
in_ready  out  1  stage accepts instruction this cycle
in_rs1_addr  in  5  source 1 index
in_rs2_addr  in  5  source 2 index
in_rd_addr  in  5  destination index
in_rd_we  in  1  instruction writes rd
in_payload  in  PAYLOAD_W  carried unchanged
rd_p1_addr  out  5  register file read port 1 address
rd_p2_addr  out  5  register file read port 2 address
rs1  in  XLEN  register file read data port 1
rs2  in  XLEN  register file read data port 2
wb_en  in  1  writeback this cycle (same signals drive register file wr_en)
wb_addr  in  5  writeback index
wb_data  in  XLEN  writeback data
out_valid  out  1  operands valid to execute
out_ready  in  1  execute accepts
out_op1  out  XLEN  source 1 value
out_op2  out  XLEN  source 2 value
out_rd_addr  out  5  destination index
out_rd_we  out  1  destination write enable
out_payload  out  PAYLOAD_W  carried payload

Behaviour:
- Reset (rst_n low, async): out_valid=0; out_op1, out_op2, out_rd_addr, out_rd_we and out_payload = 0; busy[31:0]=0. Reset mid-handshake drops the instruction with no other effect.
- rd_p1_addr=in_rs1_addr and rd_p2_addr=in_rs2_addr, combinationally and at all times.
- wb_hit(x) = wb_en && wb_addr==x && x!=0.
- src_stall(x) = x!=0 && busy[x] && !wb_hit(x).
- waw_stall = in_rd_we && in_rd_addr!=0 && busy[in_rd_addr] && !wb_hit(in_rd_addr).
- in_ready = !src_stall(rs1) && !src_stall(rs2) && !waw_stall && !flush && (!out_valid || out_ready). Combinational; in_ready may depend on in_* fields.
- Operand select:
  - x==0 -> 0
  - else wb_hit -> wb_data
  - else register file data
- fire = in_valid && in_ready. On fire at posedge:
  - output register loads the selected operands, rd fields and payload; out_valid=1.
  - if in_rd_we && rd!=0: busy[rd] is set.
  - Latency: in -> out = 1 cycle.
- out_ready && out_valid without fire: out_valid=0 next cycle. out_* stay stable while out_valid && !out_ready.
- Writeback: wb_en && wb_addr!=0 clears busy[wb_addr] at posedge. Simultaneous set (fire) and clear of the same index: set wins. x0 is never busy.
- flush (synchronous, sampled at posedge):
  - out_valid=0.
  - if the held instruction has out_rd_we && out_rd_addr!=0, its busy bit is cleared. A same-cycle clear by wb_en is harmless.
  - No fire occurs on a flush cycle.
  - flush has priority over out_ready.
- Throughput: 1 instruction per cycle with no hazards and out_ready held high.

Test Plan:
- Reset: assert rst_n=0 mid-operation -> out_valid=0, busy all 0, in_ready=1 once rst_n=1 with out_ready=1.
- Back-to-back independent: issue add x1=x2+x3 then add x4=x5+x6 (rs from register file = 7, 9, 11, 13) -> out_valid on consecutive cycles with op pairs (7,9) then (11,13), in_ready stays 1.
- RAW stall + bypass: issue rd=x1, then an instr reading x1 -> in_ready=0 until the cycle wb_en=1, wb_addr=1, wb_data=45. In that cycle it fires with out_op1=45. busy[1] clears.
- x0 handling: rs1=0 with the register file returning 0xDEAD -> out_op1=0. rd=0 with rd_we=1 -> no busy bit is set, and a following x0 reader does not stall.
- Backpressure: out_ready=0 for 3 cycles -> out_* are held constant, in_ready=0, and no new busy bits are set. Release -> the next instruction fires in the same cycle.
- WAW + flush: held instr rd=x5 with out_ready=0, then a new instr with rd=x5 -> stalls. Assert flush -> out_valid=0 and busy[5]=0; the x5 instruction fires the cycle after flush.

Source files
------------

// File: rtl/reg_read_stage_if.sv
// Handshake bundle between decode, the register-read stage and execute.
// master = upstream/downstream environment, slave = the register-read stage.
interface reg_read_stage_if #(
   parameter int XLEN      = 32,
   parameter int PAYLOAD_W = 32
);
   logic                 in_valid;
   logic                 in_ready;
   logic [4:0]           in_rs1_addr;
   logic [4:0]           in_rs2_addr;
   logic [4:0]           in_rd_addr;
   logic                 in_rd_we;
   logic [PAYLOAD_W-1:0] in_payload;

   logic                 out_valid;
   logic                 out_ready;
   logic [XLEN-1:0]      out_op1;
   logic [XLEN-1:0]      out_op2;
   logic [4:0]           out_rd_addr;
   logic                 out_rd_we;
   logic [PAYLOAD_W-1:0] out_payload;

   modport master (
      output in_valid, in_rs1_addr, in_rs2_addr, in_rd_addr, in_rd_we, in_payload,
      input  in_ready,
      input  out_valid, out_op1, out_op2, out_rd_addr, out_rd_we, out_payload,
      output out_ready
   );

   modport slave (
      input  in_valid, in_rs1_addr, in_rs2_addr, in_rd_addr, in_rd_we, in_payload,
      output in_ready,
      output out_valid, out_op1, out_op2, out_rd_addr, out_rd_we, out_payload,
      input  out_ready
   );
endinterface

// File: rtl/reg_read_stage.sv
// Register-read stage: busy-bit scoreboard for RAW/WAW stalls, writeback bypass,
// and a single output register toward execute.
module reg_read_stage #(
   parameter int XLEN      = 32,
   parameter int PAYLOAD_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   reg_read_stage_if.slave   bus,
   output logic [4:0]        rd_p1_addr,
   output logic [4:0]        rd_p2_addr,
   input  logic [XLEN-1:0]   rs1,
   input  logic [XLEN-1:0]   rs2,
   input  logic              wb_en,
   input  logic [4:0]        wb_addr,
   input  logic [XLEN-1:0]   wb_data
);

   logic [31:0]     busy;
   logic [31:0]     busy_nxt;
   logic            hit1, hit2, hitd;
   logic            stall1, stall2, stall_waw;
   logic            fire;
   logic [XLEN-1:0] op1_sel, op2_sel;

   assign rd_p1_addr = bus.in_rs1_addr;
   assign rd_p2_addr = bus.in_rs2_addr;

   always_comb begin
      hit1 = wb_en && (wb_addr == bus.in_rs1_addr) && (bus.in_rs1_addr != 5'd0);
      hit2 = wb_en && (wb_addr == bus.in_rs2_addr) && (bus.in_rs2_addr != 5'd0);
      hitd = wb_en && (wb_addr == bus.in_rd_addr)  && (bus.in_rd_addr  != 5'd0);

      stall1    = (bus.in_rs1_addr != 5'd0) && busy[bus.in_rs1_addr] && !hit1;
      stall2    = (bus.in_rs2_addr != 5'd0) && busy[bus.in_rs2_addr] && !hit2;
      stall_waw = bus.in_rd_we && (bus.in_rd_addr != 5'd0) && busy[bus.in_rd_addr] && !hitd;

      bus.in_ready = !stall1 && !stall2 && !stall_waw && !flush &&
                     (!bus.out_valid || bus.out_ready);
      fire = bus.in_valid && bus.in_ready;

      if (bus.in_rs1_addr == 5'd0) op1_sel = '0;
      else if (hit1)               op1_sel = wb_data;
      else                         op1_sel = rs1;

      if (bus.in_rs2_addr == 5'd0) op2_sel = '0;
      else if (hit2)               op2_sel = wb_data;
      else                         op2_sel = rs2;
   end

   // Clears first, then the issuing instruction's set so a same-index set wins.
   always_comb begin
      busy_nxt = busy;
      if (wb_en && (wb_addr != 5'd0))
         busy_nxt[wb_addr] = 1'b0;
      if (flush && bus.out_valid && bus.out_rd_we && (bus.out_rd_addr != 5'd0))
         busy_nxt[bus.out_rd_addr] = 1'b0;
      if (fire && bus.in_rd_we && (bus.in_rd_addr != 5'd0))
         busy_nxt[bus.in_rd_addr] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= '0;
      end else begin
         busy <= busy_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.out_valid   <= 1'b0;
         bus.out_op1     <= '0;
         bus.out_op2     <= '0;
         bus.out_rd_addr <= '0;
         bus.out_rd_we   <= 1'b0;
         bus.out_payload <= '0;
      end else if (flush) begin
         bus.out_valid <= 1'b0;
      end else if (fire) begin
         bus.out_valid   <= 1'b1;
         bus.out_op1     <= op1_sel;
         bus.out_op2     <= op2_sel;
         bus.out_rd_addr <= bus.in_rd_addr;
         bus.out_rd_we   <= bus.in_rd_we;
         bus.out_payload <= bus.in_payload;
      end else if (bus.out_ready) begin
         bus.out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_reg_read_stage.sv
// Directed bench for reg_read_stage: scoreboard of expected operand bundles
// pushed at issue and popped when execute accepts (or flush kills) them.
module tb_reg_read_stage;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic [4:0]  rd_p1_addr, rd_p2_addr;
   logic [31:0] rs1, rs2;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic [31:0] rf [32];

   int n_cmp = 0;
   int n_err = 0;

   typedef struct packed {
      logic [31:0] op1;
      logic [31:0] op2;
      logic [4:0]  rd;
      logic        we;
      logic [31:0] pl;
   } exp_t;

   exp_t sb[$];

   reg_read_stage_if #(.XLEN(32), .PAYLOAD_W(32)) ifc ();

   reg_read_stage #(.XLEN(32), .PAYLOAD_W(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .bus        (ifc.slave),
      .rd_p1_addr (rd_p1_addr),
      .rd_p2_addr (rd_p2_addr),
      .rs1        (rs1),
      .rs2        (rs2),
      .wb_en      (wb_en),
      .wb_addr    (wb_addr),
      .wb_data    (wb_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file model: combinational read, negedge write.
   assign rs1 = rf[rd_p1_addr];
   assign rs2 = rf[rd_p2_addr];
   always @(negedge clk) if (wb_en) rf[wb_addr] <= wb_data;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   task automatic drive(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] rd,
                        input logic we, input logic [31:0] pl);
      ifc.in_valid    = 1'b1;
      ifc.in_rs1_addr = a1;
      ifc.in_rs2_addr = a2;
      ifc.in_rd_addr  = rd;
      ifc.in_rd_we    = we;
      ifc.in_payload  = pl;
   endtask

   task automatic push(input logic [31:0] e1, input logic [31:0] e2, input logic [4:0] rd,
                       input logic we, input logic [31:0] pl);
      exp_t e;
      e.op1 = e1; e.op2 = e2; e.rd = rd; e.we = we; e.pl = pl;
      sb.push_back(e);
   endtask

   // Output monitor: a flushed instruction is discarded, an accepted one compared.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && ifc.out_valid) begin
         if (flush || ifc.out_ready) begin
            if (sb.size() == 0) begin
               chk("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
               e = sb.pop_front();
               chk("out_payload", ifc.out_payload, e.pl);
               if (!flush) begin
                  chk("out_op1", ifc.out_op1, e.op1);
                  chk("out_op2", ifc.out_op2, e.op2);
                  chk("out_rd_addr", 32'(ifc.out_rd_addr), 32'(e.rd));
                  chk("out_rd_we", 32'(ifc.out_rd_we), 32'(e.we));
               end
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = 32'(100 + i);
      rf[0] = 32'hDEAD;
      rf[2] = 32'd7;  rf[3] = 32'd9;
      rf[5] = 32'd11; rf[6] = 32'd13;

      rst_n = 1'b0; flush = 1'b0;
      wb_en = 1'b0; wb_addr = '0; wb_data = '0;
      ifc.in_valid = 1'b0; ifc.in_rs1_addr = '0; ifc.in_rs2_addr = '0;
      ifc.in_rd_addr = '0; ifc.in_rd_we = 1'b0; ifc.in_payload = '0;
      ifc.out_ready = 1'b1;

      at_neg();
      chk("rst_out_valid", 32'(ifc.out_valid), 32'd0);
      chk("rst_out_op2", ifc.out_op2, 32'd0);
      chk("rst_out_rd_addr", 32'(ifc.out_rd_addr), 32'd0);
      chk("rst_out_payload", ifc.out_payload, 32'd0);
      tick();
      rst_n = 1'b1;
      at_neg();
      chk("rst_in_ready", 32'(ifc.in_ready), 32'd1);
      tick();

      // Back-to-back independent instructions
      drive(5'd2, 5'd3, 5'd1, 1'b1, 32'h100);
      at_neg();
      chk("b2b_ready0", 32'(ifc.in_ready), 32'd1);
      chk("rd_p1_addr", 32'(rd_p1_addr), 32'd2);
      chk("rd_p2_addr", 32'(rd_p2_addr), 32'd3);
      push(32'd7, 32'd9, 5'd1, 1'b1, 32'h100);
      tick();
      drive(5'd5, 5'd6, 5'd4, 1'b1, 32'h101);
      at_neg();
      chk("b2b_ready1", 32'(ifc.in_ready), 32'd1);
      chk("b2b_valid0", 32'(ifc.out_valid), 32'd1);
      push(32'd11, 32'd13, 5'd4, 1'b1, 32'h101);
      tick();

      // RAW on x1, released by same-cycle writeback
      drive(5'd1, 5'd3, 5'd7, 1'b1, 32'h102);
      at_neg();
      chk("b2b_valid1", 32'(ifc.out_valid), 32'd1);
      chk("raw_stall0", 32'(ifc.in_ready), 32'd0);
      tick();
      at_neg();
      chk("raw_stall1", 32'(ifc.in_ready), 32'd0);
      tick();
      wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'd45;
      at_neg();
      chk("raw_bypass_ready", 32'(ifc.in_ready), 32'd1);
      push(32'd45, 32'd9, 5'd7, 1'b1, 32'h102);
      tick();
      wb_en = 1'b0;

      // busy[1] cleared; x0 source reads zero; rd=x0 marks nothing
      drive(5'd1, 5'd0, 5'd0, 1'b1, 32'h103);
      at_neg();
      chk("busy1_cleared", 32'(ifc.in_ready), 32'd1);
      push(32'd45, 32'd0, 5'd0, 1'b1, 32'h103);
      tick();
      drive(5'd0, 5'd0, 5'd8, 1'b0, 32'h104);
      at_neg();
      chk("x0_reader", 32'(ifc.in_ready), 32'd1);
      push(32'd0, 32'd0, 5'd8, 1'b0, 32'h104);
      tick();

      // RAW on rs2 (x4) with bypass
      drive(5'd2, 5'd4, 5'd9, 1'b1, 32'h105);
      at_neg();
      chk("raw_rs2_stall", 32'(ifc.in_ready), 32'd0);
      tick();
      wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'd77;
      at_neg();
      chk("raw_rs2_ready", 32'(ifc.in_ready), 32'd1);
      push(32'd7, 32'd77, 5'd9, 1'b1, 32'h105);
      tick();
      wb_en = 1'b0;

      // Backpressure: hold for 3 cycles, then release
      drive(5'd3, 5'd5, 5'd10, 1'b1, 32'h106);
      at_neg();
      chk("bp_issue", 32'(ifc.in_ready), 32'd1);
      push(32'd9, 32'd11, 5'd10, 1'b1, 32'h106);
      tick();
      ifc.out_ready = 1'b0;
      drive(5'd0, 5'd0, 5'd11, 1'b1, 32'h107);
      for (int c = 0; c < 3; c++) begin
         at_neg();
         chk("bp_in_ready", 32'(ifc.in_ready), 32'd0);
         chk("bp_hold_op1", ifc.out_op1, 32'd9);
         chk("bp_hold_op2", ifc.out_op2, 32'd11);
         chk("bp_hold_payload", ifc.out_payload, 32'h106);
         tick();
      end
      ifc.out_ready = 1'b1;
      at_neg();
      chk("bp_release", 32'(ifc.in_ready), 32'd1);
      push(32'd0, 32'd0, 5'd11, 1'b1, 32'h107);
      tick();

      // WAW on x5 against a held instruction, resolved by flush
      drive(5'd0, 5'd0, 5'd5, 1'b1, 32'h108);
      at_neg();
      chk("waw_first", 32'(ifc.in_ready), 32'd1);
      push(32'd0, 32'd0, 5'd5, 1'b1, 32'h108);
      tick();
      ifc.out_ready = 1'b0;
      drive(5'd2, 5'd3, 5'd5, 1'b1, 32'h109);
      at_neg();
      chk("waw_stall0", 32'(ifc.in_ready), 32'd0);
      tick();
      at_neg();
      chk("waw_stall1", 32'(ifc.in_ready), 32'd0);
      tick();
      flush = 1'b1;
      at_neg();
      chk("flush_no_fire", 32'(ifc.in_ready), 32'd0);
      tick();
      flush = 1'b0;
      at_neg();
      chk("flush_out_valid", 32'(ifc.out_valid), 32'd0);
      chk("flush_busy5_clr", 32'(ifc.in_ready), 32'd1);
      push(32'd7, 32'd9, 5'd5, 1'b1, 32'h109);
      tick();
      ifc.out_ready = 1'b1;

      // Reset while an instruction stalls on busy x10/x7
      drive(5'd10, 5'd7, 5'd12, 1'b1, 32'h10A);
      at_neg();
      chk("pre_rst_stall", 32'(ifc.in_ready), 32'd0);
      tick();
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", 32'(ifc.out_valid), 32'd0);
      chk("mid_rst_out_op1", ifc.out_op1, 32'd0);
      chk("mid_rst_out_we", 32'(ifc.out_rd_we), 32'd0);
      tick();
      rst_n = 1'b1;
      at_neg();
      chk("post_rst_ready", 32'(ifc.in_ready), 32'd1);
      push(32'd110, 32'd107, 5'd12, 1'b1, 32'h10A);
      tick();
      ifc.in_valid = 1'b0;
      tick();
      tick();
      at_neg();
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
